// File: rtl/mem_sequencer_if.sv
// Bundles the pipeline request, the memory access and the status signals of the
// memory sequencer. The sequencer sits on the slave side. The pipeline/memory
// environment sits on the master side.
interface mem_sequencer_if;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic [15:0] rd_data;
  logic        done;
  logic        err;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, mem_ready, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, stall, rd_data, done, err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, mem_ready, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, stall, rd_data, done, err
  );
endinterface

// File: rtl/mem_sequencer.sv
// Memory sequencer: accepts one load or store request from the pipeline,
// holds the pipeline while the memory access is in flight, and reports
// completion (done) or rejection/timeout (err) with a one-cycle pulse.
module mem_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  mem_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Wait count reached on the last BUSY cycle that may still complete.
  localparam logic [3:0] WCNT_LAST = 4'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic [15:0] rd_data_q;

  logic req_any;
  logic req_valid;

  // A request is legal only with exactly one direction and a halfword-aligned address.
  assign req_any   = bus.req_rd | bus.req_wr;
  assign req_valid = (bus.req_rd ^ bus.req_wr) & ~bus.req_addr[0];

  // Sequencer state, latched access and captured load data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_q      <= 1'b0;
      rd_data_q <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wr_q    <= bus.req_wr;
            wcnt    <= 4'd0;
            state   <= BUSY;
          end else if (req_any) begin
            state <= ERR;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (!wr_q) begin
              rd_data_q <= bus.mem_rdata;
            end
            state <= DONE;
          end else begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == WCNT_LAST) begin
              state <= ERR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and memory enables are forced low while reset is held so that the
  // pipeline never sees a stall or pulse from a stale state.
  assign bus.mem_en    = rst & (state == BUSY);
  assign bus.stall     = rst & ((state == BUSY) | ((state == IDLE) & req_valid));
  assign bus.done      = rst & (state == DONE);
  assign bus.err       = rst & (state == ERR);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rd_data   = rd_data_q;

endmodule
